prog_clk_gen: RTL and testbench

PROG_CLK_GEN -- requirements
Module: prog_clk_gen

---
 rtl/prog_clk_gen_if.sv | 26 ++
 rtl/prog_clk_gen.sv | 175 +++++++++++++++++
 tb/tb_prog_clk_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/prog_clk_gen_if.sv
// Configuration and output bundle of the programmable clock generator.
// The master side offers configuration and enable; the slave side is the generator.
interface prog_clk_gen_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_phase;
  logic [CNT_W-1:0] cfg_ton;
  logic [CNT_W-1:0] cfg_toff;
  logic             clk_out;
  logic             busy;
  logic             cfg_err;
  logic [7:0]       rise_cnt;

  modport master (
    output enable, cfg_valid, cfg_phase, cfg_ton, cfg_toff,
    input  cfg_ready, clk_out, busy, cfg_err, rise_cnt
  );

  modport slave (
    input  enable, cfg_valid, cfg_phase, cfg_ton, cfg_toff,
    output cfg_ready, clk_out, busy, cfg_err, rise_cnt
  );
endinterface

// File: rtl/prog_clk_gen.sv
// Programmable clock generator: start phase delay, then ton high / toff low cycles,
// with glitch-free reconfiguration applied at period boundaries.
module prog_clk_gen #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  prog_clk_gen_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PHASE = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] LOW   = 2'd3;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  logic [1:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] act_phase_r, act_ton_r, act_toff_r;
  logic [CNT_W-1:0] act_phase_nxt_s, act_ton_nxt_s, act_toff_nxt_s;
  logic [CNT_W-1:0] pend_phase_r, pend_ton_r, pend_toff_r;
  logic [CNT_W-1:0] pend_phase_nxt_s, pend_ton_nxt_s, pend_toff_nxt_s;
  logic             pend_vld_r, pend_vld_nxt_s;
  logic             clk_out_r, busy_r, cfg_err_r;
  logic [7:0]       rise_cnt_r;
  logic             hs_s, bad_s, good_s, rise_s;

  assign hs_s   = bus.cfg_valid & ~pend_vld_r;
  assign bad_s  = (bus.cfg_ton == ZERO) | (bus.cfg_toff == ZERO);
  assign good_s = hs_s & ~bad_s;

  assign bus.cfg_ready = ~pend_vld_r;
  assign bus.clk_out   = clk_out_r;
  assign bus.busy      = busy_r;
  assign bus.cfg_err   = cfg_err_r;
  assign bus.rise_cnt  = rise_cnt_r;

  // Next-state, counter and configuration-register update logic.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    act_phase_nxt_s  = act_phase_r;
    act_ton_nxt_s    = act_ton_r;
    act_toff_nxt_s   = act_toff_r;
    pend_phase_nxt_s = pend_phase_r;
    pend_ton_nxt_s   = pend_ton_r;
    pend_toff_nxt_s  = pend_toff_r;
    pend_vld_nxt_s   = pend_vld_r;
    rise_s           = 1'b0;

    if (state_r == IDLE) begin
      if (bus.enable) begin
        if (act_phase_r == ZERO) begin
          state_nxt_s = HIGH;
          cnt_nxt_s   = act_ton_r - ONE;
          rise_s      = 1'b1;
        end else begin
          state_nxt_s = PHASE;
          cnt_nxt_s   = act_phase_r - ONE;
        end
      end else begin
        state_nxt_s = IDLE;
      end
      if (good_s) begin
        act_phase_nxt_s = bus.cfg_phase;
        act_ton_nxt_s   = bus.cfg_ton;
        act_toff_nxt_s  = bus.cfg_toff;
      end else begin
        act_phase_nxt_s = act_phase_r;
      end
    end else if (!bus.enable) begin
      // Stopping: the newest accepted config wins and nothing stays pending in IDLE.
      state_nxt_s    = IDLE;
      cnt_nxt_s      = ZERO;
      pend_vld_nxt_s = 1'b0;
      if (good_s) begin
        act_phase_nxt_s = bus.cfg_phase;
        act_ton_nxt_s   = bus.cfg_ton;
        act_toff_nxt_s  = bus.cfg_toff;
      end else if (pend_vld_r) begin
        act_phase_nxt_s = pend_phase_r;
        act_ton_nxt_s   = pend_ton_r;
        act_toff_nxt_s  = pend_toff_r;
      end else begin
        act_phase_nxt_s = act_phase_r;
      end
    end else begin
      case (state_r)
        PHASE: begin
          if (cnt_r == ZERO) begin
            state_nxt_s = HIGH;
            cnt_nxt_s   = act_ton_r - ONE;
            rise_s      = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r - ONE;
          end
        end
        HIGH: begin
          if (cnt_r == ZERO) begin
            state_nxt_s = LOW;
            cnt_nxt_s   = act_toff_r - ONE;
          end else begin
            cnt_nxt_s = cnt_r - ONE;
          end
        end
        LOW: begin
          if (cnt_r == ZERO) begin
            state_nxt_s = HIGH;
            rise_s      = 1'b1;
            if (pend_vld_r) begin
              act_phase_nxt_s = pend_phase_r;
              act_ton_nxt_s   = pend_ton_r;
              act_toff_nxt_s  = pend_toff_r;
              pend_vld_nxt_s  = 1'b0;
              cnt_nxt_s       = pend_ton_r - ONE;
            end else begin
              cnt_nxt_s = act_ton_r - ONE;
            end
          end else begin
            cnt_nxt_s = cnt_r - ONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = ZERO;
        end
      endcase
      // A handshake is only possible with no pending entry, so it never collides with the load above.
      if (good_s) begin
        pend_phase_nxt_s = bus.cfg_phase;
        pend_ton_nxt_s   = bus.cfg_ton;
        pend_toff_nxt_s  = bus.cfg_toff;
        pend_vld_nxt_s   = 1'b1;
      end else begin
        pend_phase_nxt_s = pend_phase_r;
      end
    end
  end

  // State, configuration and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= ZERO;
      act_phase_r  <= ZERO;
      act_ton_r    <= ONE;
      act_toff_r   <= ONE;
      pend_phase_r <= ZERO;
      pend_ton_r   <= ZERO;
      pend_toff_r  <= ZERO;
      pend_vld_r   <= 1'b0;
      clk_out_r    <= 1'b0;
      busy_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
      rise_cnt_r   <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      act_phase_r  <= act_phase_nxt_s;
      act_ton_r    <= act_ton_nxt_s;
      act_toff_r   <= act_toff_nxt_s;
      pend_phase_r <= pend_phase_nxt_s;
      pend_ton_r   <= pend_ton_nxt_s;
      pend_toff_r  <= pend_toff_nxt_s;
      pend_vld_r   <= pend_vld_nxt_s;
      clk_out_r    <= (state_nxt_s == HIGH);
      busy_r       <= (state_nxt_s != IDLE);
      cfg_err_r    <= hs_s & bad_s;
      rise_cnt_r   <= rise_s ? (rise_cnt_r + 8'd1) : rise_cnt_r;
    end
  end

endmodule

// File: tb/tb_prog_clk_gen.sv
// Directed plus randomized bench for prog_clk_gen against a period-position model.
module tb_prog_clk_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  prog_clk_gen_if #(.CNT_W(16)) bus ();

  prog_clk_gen #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position within the current output period (negative while in the phase delay).
  bit m_run;
  int m_pos;
  int m_ph, m_ton, m_toff;
  bit m_pvld;
  int m_pph, m_pton, m_ptoff;
  int m_rise;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0;
    m_ph = 0; m_ton = 1; m_toff = 1;
    m_pvld = 1'b0; m_pph = 0; m_pton = 0; m_ptoff = 0;
    m_rise = 0; m_err = 1'b0;
  endtask

  task automatic check_all();
    chk("clk_out",   {31'd0, bus.clk_out},   {31'd0, (m_run && m_pos >= 0 && m_pos < m_ton)});
    chk("busy",      {31'd0, bus.busy},      {31'd0, m_run});
    chk("cfg_ready", {31'd0, bus.cfg_ready}, {31'd0, !m_pvld});
    chk("cfg_err",   {31'd0, bus.cfg_err},   {31'd0, m_err});
    chk("rise_cnt",  {24'd0, bus.rise_cnt},  m_rise);
  endtask

  task automatic step(input bit en, input bit v, input int ph, input int ton, input int toff);
    bit hs;
    bit good;
    bus.enable    = en;
    bus.cfg_valid = v;
    bus.cfg_phase = ph[15:0];
    bus.cfg_ton   = ton[15:0];
    bus.cfg_toff  = toff[15:0];
    hs   = v && !m_pvld;
    good = hs && (ton != 0) && (toff != 0);
    @(posedge clk);
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_pos = -m_ph;
      end
      if (good) begin m_ph = ph; m_ton = ton; m_toff = toff; end
    end else if (!en) begin
      m_run = 1'b0;
      if (good) begin m_ph = ph; m_ton = ton; m_toff = toff; end
      else if (m_pvld) begin m_ph = m_pph; m_ton = m_pton; m_toff = m_ptoff; end
      m_pvld = 1'b0;
    end else begin
      m_pos++;
      if (m_pos == m_ton + m_toff) begin
        m_pos = 0;
        if (m_pvld) begin m_ph = m_pph; m_ton = m_pton; m_toff = m_ptoff; m_pvld = 1'b0; end
      end
      if (good) begin m_pph = ph; m_pton = ton; m_ptoff = toff; m_pvld = 1'b1; end
    end
    if (m_run && m_pos == 0) m_rise = (m_rise + 1) % 256;
    m_err = hs && !good;
    #1;
    check_all();
  endtask

  initial begin
    bit cur_en;
    int n;
    checks = 0; failures = 0;
    model_reset();
    bus.enable = 1'b0; bus.cfg_valid = 1'b0;
    bus.cfg_phase = 16'd0; bus.cfg_ton = 16'd0; bus.cfg_toff = 16'd0;
    rst_n = 1'b0;
    #12;
    check_all();
    rst_n = 1'b1;

    // Reset defaults: clk/2 straight after enable.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);

    // 10% duty with a 2-cycle start delay.
    step(1'b0, 1'b1, 2, 1, 9);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);

    // Reconfigure mid-HIGH: 3/3 finishes, then 2/6.
    step(1'b0, 1'b1, 0, 3, 3);
    n = 0;
    do begin step(1'b1, 1'b0, 0, 0, 0); n++; end while (!(m_run && m_pos == 1) && n < 50);
    chk("mid_high_reached", {31'd0, bus.clk_out}, 32'd1);
    step(1'b1, 1'b1, 0, 2, 6);
    chk("ready_low_pending", {31'd0, bus.cfg_ready}, 32'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 0, 0, 0);

    // Rejected configs leave timing alone.
    step(1'b1, 1'b1, 1, 0, 5);
    step(1'b1, 1'b1, 1, 4, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 0, 0);

    // Disable mid-HIGH, then re-enable with a phase delay.
    n = 0;
    while (!(m_pos >= 0 && m_pos < m_ton) && n < 50) begin step(1'b1, 1'b0, 0, 0, 0); n++; end
    step(1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b1, 3, 2, 2);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 0, 0, 0);

    // Randomized traffic.
    cur_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bit v;
      if ($urandom_range(0, 29) == 0) cur_en = !cur_en;
      v = ($urandom_range(0, 5) == 0) && ((m_run && cur_en) || (!m_run && !cur_en));
      step(cur_en, v, $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 5));
    end

    // Async reset, then 256 rising edges wrap the counter.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 511; i++) step(1'b1, 1'b0, 0, 0, 0);
    chk("rise_wrap", {24'd0, bus.rise_cnt}, 32'd0);

    // Reset asserted between edges while clk_out is high.
    chk("pre_reset_high", {31'd0, bus.clk_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clk_out", {31'd0, bus.clk_out}, 32'd0);
    model_reset();
    check_all();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
